// File: rtl/traffic_phase_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_phase_arbiter: four-approach round-robin signal phase controller |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module traffic_phase_arbiter #(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 1,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] req,
    output logic [1:0] north,
    output logic [1:0] east,
    output logic [1:0] south,
    output logic [1:0] west,
    output logic [3:0] grant,
    output logic       phase_start
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_ALLRED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_MIN_GREEN = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] C_MAX_GREEN = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] C_YELLOW_T  = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] C_ALLRED_T  = CNT_W'(ALLRED_T);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0][1:0]  lights_q, lights_d;
    logic [3:0]       grant_q, grant_d;
    logic             phase_start_q, phase_start_d;

    logic [3:0]       w_cand;
    logic             w_win_found;
    logic [1:0]       w_win_idx;
    logic [3:0]       w_win_oh;
    logic [3:0]       w_cur_oh;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_grant_now;

    // Round-robin scan from ptr; iterating downward lets the closest hit win.
    assign w_cand = pending_q | req;

    always_comb begin
        logic [1:0] idx;
        w_win_found = 1'b0;
        w_win_idx   = ptr_q;
        idx         = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (w_cand[idx]) begin
                w_win_idx   = idx;
                w_win_found = 1'b1;
            end
        end
    end

    assign w_win_oh  = 4'b0001 << w_win_idx;
    assign w_cur_oh  = 4'b0001 << cur_q;
    assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        ptr_d       = ptr_q;
        w_grant_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_win_found) begin
                    state_d     = S_GREEN;
                    cur_d       = w_win_idx;
                    ptr_d       = w_win_idx + 2'd1;
                    cnt_d       = '0;
                    w_grant_now = 1'b1;
                end
            end
            S_GREEN: begin
                if (tick) begin
                    cnt_d = w_cnt_inc;
                    if ((w_cnt_inc == C_MAX_GREEN) ||
                        ((w_cnt_inc >= C_MIN_GREEN) &&
                         (!req[cur_q] || |(pending_q & ~w_cur_oh)))) begin
                        state_d = S_YELLOW;
                        cnt_d   = '0;
                    end
                end
            end
            S_YELLOW: begin
                if (tick) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc >= C_YELLOW_T) begin
                        state_d = S_ALLRED;
                        cnt_d   = '0;
                    end
                end
            end
            S_ALLRED: begin
                if (tick) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc >= C_ALLRED_T) begin
                        cnt_d = '0;
                        if (w_win_found) begin
                            state_d     = S_GREEN;
                            cur_d       = w_win_idx;
                            ptr_d       = w_win_idx + 2'd1;
                            w_grant_now = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The served approach's own requests are ignored while it holds the road.
    always_comb begin
        logic [3:0] mask;
        mask = ((state_q == S_GREEN) || (state_q == S_YELLOW)) ? w_cur_oh : 4'b0000;
        pending_d = (pending_q | (req & ~mask)) & ~(w_grant_now ? w_win_oh : 4'b0000);
    end

    always_comb begin
        lights_d      = '0;
        grant_d       = 4'b0000;
        phase_start_d = w_grant_now;
        if (state_d == S_GREEN) begin
            lights_d[cur_d] = 2'b10;
            grant_d         = 4'b0001 << cur_d;
        end else if (state_d == S_YELLOW) begin
            lights_d[cur_d] = 2'b01;
            grant_d         = 4'b0001 << cur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cur_q         <= 2'd0;
            ptr_q         <= 2'd0;
            pending_q     <= 4'b0000;
            lights_q      <= '0;
            grant_q       <= 4'b0000;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_q         <= cur_d;
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            lights_q      <= lights_d;
            grant_q       <= grant_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign north       = lights_q[0];
    assign east        = lights_q[1];
    assign south       = lights_q[2];
    assign west        = lights_q[3];
    assign grant       = grant_q;
    assign phase_start = phase_start_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_traffic_phase_arbiter: directed bench for traffic_phase_arbiter       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_traffic_phase_arbiter;

    localparam logic [7:0] C_N_G = 8'b00_00_00_10;
    localparam logic [7:0] C_N_Y = 8'b00_00_00_01;
    localparam logic [7:0] C_E_G = 8'b00_00_10_00;
    localparam logic [7:0] C_E_Y = 8'b00_00_01_00;
    localparam logic [7:0] C_S_G = 8'b00_10_00_00;
    localparam logic [7:0] C_S_Y = 8'b00_01_00_00;
    localparam logic [7:0] C_W_G = 8'b10_00_00_00;
    localparam logic [7:0] C_W_Y = 8'b01_00_00_00;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] req;
    logic [1:0] north, east, south, west;
    logic [3:0] grant;
    logic       phase_start;
    logic [7:0] lights;

    int n_assert = 0;
    int n_fail   = 0;

    traffic_phase_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .req         (req),
        .north       (north),
        .east        (east),
        .south       (south),
        .west        (west),
        .grant       (grant),
        .phase_start (phase_start)
    );

    always #5 clk = ~clk;

    assign lights = {west, south, east, north};

    function automatic bit legal(input logic [7:0] l);
        int nz = 0;
        for (int i = 0; i < 4; i++) begin
            if (l[2*i +: 2] === 2'b11) return 1'b0;
            if (l[2*i +: 2] !== 2'b00) nz++;
        end
        return (nz <= 1);
    endfunction

    task automatic expect_out(input string tag, input logic [7:0] l,
                              input logic [3:0] g, input logic ps);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {3'b000, phase_start, grant, lights};
        exp = {3'b000, ps, g, l};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed={ps,grant,lights}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1 ns after the edge and check light legality.
    task automatic cyc(input logic [3:0] r, input logic t);
        req  = r;
        tick = t;
        @(posedge clk);
        #1;
        n_assert++;
        assert (legal(lights)) else begin
            n_fail++;
            $error("FAIL legal_lights observed=%b expected=at most one non-red, no 11", lights);
        end
    endtask

    task automatic tcyc(input logic [3:0] r);
        cyc(r, 1'b1);
        cyc(r, 1'b0);
    endtask

    // Caller has just seen the green start; runs a minimum-length phase to all-red.
    task automatic run_phase(input string tag, input logic [7:0] gl,
                             input logic [7:0] yl, input logic [3:0] g,
                             input logic [3:0] r);
        cyc(r, 1'b0);
        expect_out({tag, "_hold"}, gl, g, 1'b0);
        repeat (4) tcyc(r);
        expect_out({tag, "_green4"}, gl, g, 1'b0);
        tcyc(r);
        expect_out({tag, "_yellow"}, yl, g, 1'b0);
        tcyc(r);
        expect_out({tag, "_allred"}, 8'h00, 4'b0000, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        tick  = 1'b0;
        repeat (3) cyc(4'b0000, 1'b0);
        expect_out("reset", 8'h00, 4'b0000, 1'b0);
        reset = 1'b0;

        // Idle with ticks running
        for (int i = 0; i < 100; i++) begin
            cyc(4'b0000, (i % 4) == 0);
            expect_out("idle_100", 8'h00, 4'b0000, 1'b0);
        end

        // Single east pulse
        cyc(4'b0010, 1'b0);
        expect_out("east_start", C_E_G, 4'b0010, 1'b1);
        run_phase("east", C_E_G, C_E_Y, 4'b0010, 4'b0000);
        tcyc(4'b0000);
        expect_out("east_idle", 8'h00, 4'b0000, 1'b0);
        repeat (3) tcyc(4'b0000);
        expect_out("east_stay_idle", 8'h00, 4'b0000, 1'b0);

        // North held: extension to MAX_GREEN, then re-served
        cyc(4'b0001, 1'b0);
        expect_out("north_start", C_N_G, 4'b0001, 1'b1);
        cyc(4'b0001, 1'b0);
        expect_out("north_ps_drop", C_N_G, 4'b0001, 1'b0);
        repeat (14) tcyc(4'b0001);
        expect_out("north_ext14", C_N_G, 4'b0001, 1'b0);
        tcyc(4'b0001);
        expect_out("north_max_yellow", C_N_Y, 4'b0001, 1'b0);
        tcyc(4'b0001);
        expect_out("north_allred", 8'h00, 4'b0000, 1'b0);
        cyc(4'b0001, 1'b1);
        expect_out("north_regrant", C_N_G, 4'b0001, 1'b1);
        run_phase("north2", C_N_G, C_N_Y, 4'b0001, 4'b0000);
        tcyc(4'b0000);
        expect_out("north2_idle", 8'h00, 4'b0000, 1'b0);

        // All four at once from a fresh pointer
        reset = 1'b1;
        cyc(4'b0000, 1'b0);
        reset = 1'b0;
        cyc(4'b1111, 1'b0);
        expect_out("rr_north", C_N_G, 4'b0001, 1'b1);
        run_phase("rr_n", C_N_G, C_N_Y, 4'b0001, 4'b0000);
        cyc(4'b0000, 1'b1);
        expect_out("rr_east", C_E_G, 4'b0010, 1'b1);
        run_phase("rr_e", C_E_G, C_E_Y, 4'b0010, 4'b0000);
        cyc(4'b0000, 1'b1);
        expect_out("rr_south", C_S_G, 4'b0100, 1'b1);
        run_phase("rr_s", C_S_G, C_S_Y, 4'b0100, 4'b0000);
        cyc(4'b0000, 1'b1);
        expect_out("rr_west", C_W_G, 4'b1000, 1'b1);
        run_phase("rr_w", C_W_G, C_W_Y, 4'b1000, 4'b0000);
        cyc(4'b0000, 1'b1);
        expect_out("rr_idle", 8'h00, 4'b0000, 1'b0);
        repeat (5) tcyc(4'b0000);
        expect_out("rr_pending_empty", 8'h00, 4'b0000, 1'b0);

        // West request cuts a held north green at MIN_GREEN
        reset = 1'b1;
        cyc(4'b0000, 1'b0);
        reset = 1'b0;
        cyc(4'b0001, 1'b0);
        expect_out("cut_north", C_N_G, 4'b0001, 1'b1);
        cyc(4'b0001, 1'b0);
        repeat (3) tcyc(4'b0001);
        cyc(4'b1001, 1'b0);
        tcyc(4'b0001);
        expect_out("cut_count4", C_N_G, 4'b0001, 1'b0);
        tcyc(4'b0001);
        expect_out("cut_yellow", C_N_Y, 4'b0001, 1'b0);
        tcyc(4'b0001);
        expect_out("cut_allred", 8'h00, 4'b0000, 1'b0);
        cyc(4'b0001, 1'b1);
        expect_out("cut_west", C_W_G, 4'b1000, 1'b1);

        // Reset mid-green discards pending and same-cycle request
        reset = 1'b1;
        cyc(4'b0000, 1'b0);
        reset = 1'b0;
        cyc(4'b0010, 1'b0);
        expect_out("rst_east", C_E_G, 4'b0010, 1'b1);
        cyc(4'b0000, 1'b0);
        repeat (2) tcyc(4'b0000);
        cyc(4'b0101, 1'b0);
        expect_out("rst_east_cnt2", C_E_G, 4'b0010, 1'b0);
        reset = 1'b1;
        cyc(4'b1000, 1'b1);
        expect_out("rst_mid_green", 8'h00, 4'b0000, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0000, (i % 2) == 0);
            expect_out("rst_pending_lost", 8'h00, 4'b0000, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_arbiter.md
TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

Interface
REQ-001 Parameter MIN_GREEN, default 5, minimum green duration in ticks (1..MAX_GREEN).
REQ-002 Parameter MAX_GREEN, default 15, maximum green duration in ticks (MIN_GREEN..2^CNT_W-1).
REQ-003 Parameter YELLOW_T, default 1, yellow duration in ticks (>=1).
REQ-004 Parameter ALLRED_T, default 1, all-red clearance in ticks (>=1).
REQ-005 Parameter CNT_W, default 5, width of the phase tick counter.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 tick  input  1  one-cycle timebase pulse (e.g. 1 s strobe), synchronous to clk.
REQ-009 req  input  4  vehicle detector requests; bit0=north, bit1=east, bit2=south, bit3=west.
REQ-010 north, east, south, west  output  2 each  registered light code: 00 red, 01 yellow, 10 green; 11 never driven.
REQ-011 grant  output  4  registered one-hot of approach currently in GREEN or YELLOW; 0 otherwise.
REQ-012 phase_start  output  1  registered one-cycle pulse in the first cycle an approach shows green.

Function
REQ-013 FSM states SHALL be IDLE, GREEN, YELLOW, ALLRED; at most one approach non-red in any cycle.
REQ-014 pending[3:0] SHALL set on any cycle req[i]=1, except for the approach in GREEN/YELLOW (ignored there); pending[i] clears on the cycle approach i is granted.
REQ-015 Arbitration: round-robin pointer ptr (reset 0=north); winner is first pending (or live req) bit scanning ptr, ptr+1, ... mod 4; on grant ptr <= winner+1 mod 4.
REQ-016 IDLE: all outputs red; in any cycle with (pending|req)!=0 arbitrate, enter GREEN next cycle; tick not required.
REQ-017 GREEN: winner output 10, phase_start=1 in first GREEN cycle; counter cleared on entry, incremented on each tick cycle, saturating at 2^CNT_W-1.
REQ-018 GREEN exit to YELLOW on the tick cycle where new count == MAX_GREEN, or new count >= MIN_GREEN and (req[cur]==0 or any other pending bit set).
REQ-019 Extension: with req[cur] held and no other pending, green holds beyond MIN_GREEN until MAX_GREEN.
REQ-020 YELLOW: current output 01 for exactly YELLOW_T ticks (counter cleared on entry), then ALLRED.
REQ-021 ALLRED: all outputs 00, grant=0, for ALLRED_T ticks; at exit arbitrate as in REQ-016 and go directly to GREEN if any pending/req, else IDLE.
REQ-022 A tick arriving in the same cycle as a state entry SHALL NOT count toward the new state.
REQ-023 Simultaneous requests SHALL be served one per cycle of phases in round-robin order; no approach waits more than 3 other phases.
REQ-024 Output latency: light codes change in the cycle after the state transition decision (registered outputs).

Reset
REQ-025 reset=1 at any clock edge, including mid-GREEN/YELLOW: next cycle state=IDLE, all lights 00, grant=0, phase_start=0, pending=0, ptr=0, counter=0.
REQ-026 reset has priority over req and tick in the same cycle; req sampled in the reset cycle is discarded.

Verification
REQ-027 Reset, req=0, ticks running 100 cycles -> all lights 00, grant=0, phase_start never pulses.
REQ-028 One-cycle req=0010 from IDLE -> next cycle east=10, grant=0010, phase_start=1; green for 5 ticks, east=01 for 1 tick, all 00 for 1 tick, then IDLE.
REQ-029 req=0001 held continuously -> north green 15 ticks, yellow 1, all-red 1, then north green again (phase_start pulses).
REQ-030 req=1111 one cycle from IDLE -> green order north, east, south, west, each 5 ticks, then IDLE with pending=0.
REQ-031 North green with req[0] held; req[3] pulse at count 3 -> north yellow at tick 5, then all-red, then west green.
REQ-032 reset asserted during east GREEN at count 2 with pending=0101 -> next cycle all 00, grant=0; subsequent req=0 keeps IDLE (pending lost).
